// File: rtl/wb_regfile_commit.sv
// wb_regfile_commit: MEM->WB pipeline register, register-file commit with flag-mask merge, read ports, retire counter
module wb_regfile_commit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      MEM_Result,
  input  logic [4:0]       MEM_Wr_id,
  input  logic [7:0]       MEM_Flags,
  input  logic [7:0]       MEM_Fmask,
  input  logic             MEM_Valid,
  input  logic             Flush,
  output logic [15:0]      WB_Result,
  output logic [4:0]       WB_Wr_id,
  output logic [7:0]       WB_Flags,
  output logic [7:0]       WB_Fmask,
  input  logic [4:0]       Rd0_id,
  output logic [15:0]      Rd_data0,
  input  logic [4:0]       Rd1_id,
  output logic [15:0]      Rd_data1,
  output logic [7:0]       F_out,
  output logic [CNT_W-1:0] RetireCnt
);
  // 8-bit IDs have bit4=0 and use the low nibble as the register index; pairs have bit4=1
  localparam logic [3:0] R_A = 4'd1, R_F = 4'd2, R_B = 4'd3, R_C = 4'd4, R_D = 4'd5, R_E = 4'd6;
  localparam logic [3:0] R_H = 4'd7, R_L = 4'd8, R_T0 = 4'd9, R_T1 = 4'd10, R_T2 = 4'd11, R_T3 = 4'd12;

  // Entry 0 stands for rR0: never written, so it always reads as zero.
  logic [7:0] rf  [16];
  logic [7:0] nxt [16];
  logic [8:0] wp, p0, p1;

  // Maps a pair ID to {mapped, high index, low index}; unmapped IDs return mapped=0.
  function automatic logic [8:0] pair_map(input logic [4:0] id);
    case (id)
      5'd16:   pair_map = {1'b1, R_A,  R_F};
      5'd17:   pair_map = {1'b1, R_B,  R_C};
      5'd18:   pair_map = {1'b1, R_D,  R_E};
      5'd19:   pair_map = {1'b1, R_H,  R_L};
      5'd20:   pair_map = {1'b1, R_T1, R_T0};
      5'd21:   pair_map = {1'b1, R_T3, R_T2};
      default: pair_map = 9'd0;
    endcase
  endfunction

  assign wp = pair_map(WB_Wr_id);
  assign p0 = pair_map(Rd0_id);
  assign p1 = pair_map(Rd1_id);

  // Next register-file state: write the WB result, then let masked flag bits override F.
  always_comb begin
    nxt[0] = 8'h00;
    for (int i = 1; i < 16; i++) begin
      nxt[i] = rf[i];
      if (!WB_Wr_id[4] && WB_Wr_id[3:0] == 4'(i)) nxt[i] = WB_Result[7:0];
      if (wp[8] && wp[3:0] == 4'(i)) nxt[i] = WB_Result[7:0];
      if (wp[8] && wp[7:4] == 4'(i)) nxt[i] = WB_Result[15:8];
    end
    nxt[R_F] = (nxt[R_F] & ~WB_Fmask) | (WB_Flags & WB_Fmask);
  end

  // Pipeline register: flushed or invalid MEM entries enter WB as a bubble.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      WB_Result <= '0;
      WB_Wr_id  <= '0;
      WB_Flags  <= '0;
      WB_Fmask  <= '0;
    end else begin
      WB_Result <= (Flush || !MEM_Valid) ? 16'h0 : MEM_Result;
      WB_Wr_id  <= (Flush || !MEM_Valid) ? 5'h0  : MEM_Wr_id;
      WB_Flags  <= (Flush || !MEM_Valid) ? 8'h0  : MEM_Flags;
      WB_Fmask  <= (Flush || !MEM_Valid) ? 8'h0  : MEM_Fmask;
    end

  // Commit the WB entry into the register file on the same edge the next one enters WB.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    else rf <= nxt;

  // Count every committed non-bubble entry, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) RetireCnt <= '0;
    else RetireCnt <= RetireCnt + CNT_W'(|{WB_Wr_id, WB_Fmask});

  assign Rd_data0 = !Rd0_id[4] ? {8'h00, rf[Rd0_id[3:0]]} : p0[8] ? {rf[p0[7:4]], rf[p0[3:0]]} : 16'h0;
  assign Rd_data1 = !Rd1_id[4] ? {8'h00, rf[Rd1_id[3:0]]} : p1[8] ? {rf[p1[7:4]], rf[p1[3:0]]} : 16'h0;
  assign F_out    = rf[R_F];
endmodule

// File: tb/tb_wb_regfile_commit.sv
// tb_wb_regfile_commit: directed table-driven checks of WB pipeline, commit, flag merge and retire counter
module tb_wb_regfile_commit;
  localparam logic [4:0] RR0 = 5'd0, RA = 5'd1, RF = 5'd2, RB = 5'd3, RC = 5'd4, RD = 5'd5, RE = 5'd6;
  localparam logic [4:0] RH = 5'd7, RL = 5'd8, RT0 = 5'd9, RT1 = 5'd10, RT3 = 5'd12;
  localparam logic [4:0] RAF = 5'd16, RBC = 5'd17, RDE = 5'd18, RHL = 5'd19, RT10 = 5'd20, RT32 = 5'd21, RUN = 5'd22;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] MEM_Result = '0;
  logic [4:0]  MEM_Wr_id = '0;
  logic [7:0]  MEM_Flags = '0;
  logic [7:0]  MEM_Fmask = '0;
  logic        MEM_Valid = 1'b0;
  logic        Flush = 1'b0;
  logic [15:0] WB_Result;
  logic [4:0]  WB_Wr_id;
  logic [7:0]  WB_Flags;
  logic [7:0]  WB_Fmask;
  logic [4:0]  Rd0_id = '0;
  logic [15:0] Rd_data0;
  logic [4:0]  Rd1_id = '0;
  logic [15:0] Rd_data1;
  logic [7:0]  F_out;
  logic [15:0] RetireCnt;

  int passed = 0;
  int total = 0;

  wb_regfile_commit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_Result(MEM_Result), .MEM_Wr_id(MEM_Wr_id), .MEM_Flags(MEM_Flags), .MEM_Fmask(MEM_Fmask),
    .MEM_Valid(MEM_Valid), .Flush(Flush),
    .WB_Result(WB_Result), .WB_Wr_id(WB_Wr_id), .WB_Flags(WB_Flags), .WB_Fmask(WB_Fmask),
    .Rd0_id(Rd0_id), .Rd_data0(Rd_data0), .Rd1_id(Rd1_id), .Rd_data1(Rd_data1),
    .F_out(F_out), .RetireCnt(RetireCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  id;
    logic [15:0] res;
    logic [7:0]  flg;
    logic [7:0]  msk;
    logic        vld;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [7:0]  ef;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Send one MEM entry, follow it with a bubble so it commits, then read back.
  task automatic apply(input int n, input vec_t v);
    @(negedge clk);
    MEM_Wr_id = v.id; MEM_Result = v.res; MEM_Flags = v.flg; MEM_Fmask = v.msk;
    MEM_Valid = v.vld; Flush = v.fl;
    @(posedge clk); #1;
    chk($sformatf("v%0d wb_result", n), WB_Result, (v.fl || !v.vld) ? 16'h0 : v.res);
    chk($sformatf("v%0d wb_wr_id", n), {11'd0, WB_Wr_id}, (v.fl || !v.vld) ? 16'h0 : {11'd0, v.id});
    @(negedge clk);
    MEM_Valid = 1'b0; Flush = 1'b0;
    @(posedge clk); #1;
    Rd0_id = v.r0; Rd1_id = v.r1; #1;
    chk($sformatf("v%0d rd0", n), Rd_data0, v.e0);
    chk($sformatf("v%0d rd1", n), Rd_data1, v.e1);
    chk($sformatf("v%0d f_out", n), {8'd0, F_out}, {8'd0, v.ef});
    chk($sformatf("v%0d retire", n), RetireCnt, v.ecnt);
  endtask

  initial begin
    //        id    res       flg    msk    vld   fl    r0    r1    e0        e1        ef     cnt
    vt[0]  = '{RHL,  16'hBEEF, 8'h00, 8'h00, 1'b1, 1'b0, RH,   RHL,  16'h00BE, 16'hBEEF, 8'h00, 16'd1};
    vt[1]  = '{RAF,  16'h12F0, 8'h0F, 8'h03, 1'b1, 1'b0, RA,   RAF,  16'h0012, 16'h12F3, 8'hF3, 16'd2};
    vt[2]  = '{RB,   16'h0055, 8'h00, 8'h00, 1'b1, 1'b1, RB,   RHL,  16'h0000, 16'hBEEF, 8'hF3, 16'd2};
    vt[3]  = '{RB,   16'h0055, 8'h00, 8'h00, 1'b0, 1'b0, RB,   RL,   16'h0000, 16'h00EF, 8'hF3, 16'd2};
    vt[4]  = '{RR0,  16'hFFFF, 8'h00, 8'h00, 1'b1, 1'b0, RR0,  RAF,  16'h0000, 16'h12F3, 8'hF3, 16'd2};
    vt[5]  = '{RF,   16'h0000, 8'h00, 8'h00, 1'b1, 1'b0, RF,   RAF,  16'h0000, 16'h1200, 8'h00, 16'd3};
    vt[6]  = '{RR0,  16'hFFFF, 8'h80, 8'h80, 1'b1, 1'b0, RAF,  RR0,  16'h1280, 16'h0000, 8'h80, 16'd4};
    vt[7]  = '{RC,   16'h0011, 8'h00, 8'h00, 1'b1, 1'b0, RC,   RBC,  16'h0011, 16'h0011, 8'h80, 16'd5};
    vt[8]  = '{RT10, 16'hA55A, 8'h00, 8'h00, 1'b1, 1'b0, RT1,  RT0,  16'h00A5, 16'h005A, 8'h80, 16'd6};
    vt[9]  = '{RT32, 16'h1234, 8'h00, 8'h00, 1'b1, 1'b0, RT32, RT3,  16'h1234, 16'h0012, 8'h80, 16'd7};
    vt[10] = '{RUN,  16'h7777, 8'h00, 8'h00, 1'b1, 1'b0, RUN,  RDE,  16'h0000, 16'h0000, 8'h80, 16'd8};
    vt[11] = '{RD,   16'h0099, 8'h01, 8'h01, 1'b1, 1'b0, RDE,  RD,   16'h9900, 16'h0099, 8'h81, 16'd9};
    vt[12] = '{RF,   16'h00AA, 8'h05, 8'h0F, 1'b1, 1'b0, RF,   RAF,  16'h00A5, 16'h12A5, 8'hA5, 16'd10};
    vt[13] = '{RE,   16'hFF33, 8'h00, 8'h00, 1'b1, 1'b0, RE,   RDE,  16'h0033, 16'h9933, 8'hA5, 16'd11};

    #2;
    chk("reset retire", RetireCnt, 16'h0);
    chk("reset wb_wr_id", {11'd0, WB_Wr_id}, 16'h0);
    chk("reset f_out", {8'd0, F_out}, 16'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(i, vt[i]);

    // Back-to-back writes to the same register; reads lag the commit by one edge.
    @(negedge clk);
    MEM_Wr_id = RC; MEM_Result = 16'h0011; MEM_Flags = 8'h00; MEM_Fmask = 8'h00; MEM_Valid = 1'b1;
    @(negedge clk);
    MEM_Result = 16'h0022;
    @(negedge clk);
    Rd0_id = RC; #1;
    chk("b2b first", Rd_data0, 16'h0011);
    MEM_Valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b second", Rd_data0, 16'h0022);

    // Asynchronous reset while a valid entry sits in WB: clears at once and never commits it.
    @(negedge clk);
    MEM_Wr_id = RA; MEM_Result = 16'h0077; MEM_Valid = 1'b1;
    @(posedge clk); #1;
    Rd0_id = RA; Rd1_id = RHL; MEM_Valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    chk("arst wb_wr_id", {11'd0, WB_Wr_id}, 16'h0);
    chk("arst wb_result", WB_Result, 16'h0);
    chk("arst retire", RetireCnt, 16'h0);
    chk("arst rd0", Rd_data0, 16'h0);
    chk("arst rd1", Rd_data1, 16'h0);
    chk("arst f_out", {8'd0, F_out}, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst no commit", Rd_data0, 16'h0);
    chk("arst retire after", RetireCnt, 16'h0);

    // Retire counter reaches all-ones and wraps to zero.
    @(negedge clk);
    MEM_Wr_id = RA; MEM_Result = 16'h0001; MEM_Valid = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk); MEM_Valid = 1'b0;
    @(posedge clk); #1;
    chk("retire max", RetireCnt, 16'hFFFF);
    @(negedge clk); MEM_Valid = 1'b1;
    @(negedge clk); MEM_Valid = 1'b0;
    @(posedge clk); #1;
    chk("retire wrap", RetireCnt, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
